fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front end. It generates the sequential fetch PC stream and issues word requests to instruction memory. In-order responses are buffered in a small FIFO and handed to decode as {pc, instr} over a valid/ready interface. Branch/jump redirects from execute flush the buffer and discard in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, buffered instruction entries (power of two, >=2); also the cap on outstanding requests plus buffered entries

Ports:
clk  input  1  clock, rising edge
res  input  1  asynchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response valid; in order, 1+ cycles after acceptance, never back-pressured
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  single-cycle pulse: change flow
redirect_pc  input  32  redirect target
instr_valid  output  1  decode-side valid
instr_ready  input  1  decode accepts
instr_data  output  32  instruction
instr_pc  output  32  PC of instr_data

Behaviour:
- Reset (res=0, asynchronous): state=BOOT; fetch_pc=RESET_PC; rsp_pc=RESET_PC; outstanding=0; discard=0; FIFO empty; imem_req_valid=0; instr_valid=0; imem_req_addr=RESET_PC.
- States: BOOT -> RUN after exactly one cycle (no request in BOOT). RUN -> FLUSH on redirect when outstanding in-flight responses are non-zero after same-cycle accounting. FLUSH -> RUN when discard reaches 0. A redirect in FLUSH restarts the discard count.
- Credit rule: imem_req_valid=1 only in RUN, with no redirect this cycle, and with outstanding+fifo_count < FIFO_DEPTH. Every accepted response therefore has a FIFO slot.
- Request accepted (valid&ready): fetch_pc += 4 (mod 2^32, wraps at 32'hFFFF_FFFC -> 0); outstanding += 1. imem_req_addr=fetch_pc, held stable while valid&!ready.
- Response in RUN: push {rsp_pc, rsp_data}; rsp_pc += 4; outstanding -= 1. Push and pop in the same cycle is legal at full and at empty.
- Output: instr_valid = FIFO non-empty. The head is registered (no combinational path from imem_rsp to instr), so minimum latency is request accept -> rsp cycle -> instr_valid next cycle. Head is held stable while valid&!ready.
- Redirect (priority over all same-cycle events):
  - FIFO cleared; pops and pushes this cycle are ignored.
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outstanding + (accept this cycle, which cannot occur since req_valid=0) - rsp_valid this cycle.
  - outstanding is set to discard.
- FLUSH: each response is dropped, with discard -= 1 and outstanding -= 1. No requests are issued. instr_valid=0.
- Reset mid-operation returns to BOOT immediately. Responses to pre-reset requests are the memory's responsibility and must not arrive.

Optional Feature:
FETCH_PERF_EN. When defined, adds output perf_fetched (32 bits) and output perf_stall (32 bits).
- perf_fetched increments on each instr_valid&instr_ready.
- perf_stall increments on each RUN cycle with imem_req_valid&!imem_req_ready.
- Both reset to 0 and wrap.
When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package riscv_fetch_pkg: XLEN=32, INSTR_BYTES=4, fetch_state_t {BOOT, RUN, FLUSH}, fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH, push, pop, clear, full, empty, count. Clear has priority over push/pop.

Test Plan:
1. Reset release, imem_req_ready=1, 1-cycle memory -> first request addr 0x0 on cycle 2 after release. instr_pc sequence 0x0, 0x4, 0x8 with matching data.
2. instr_ready=0 for 10 cycles -> at most FIFO_DEPTH=2 requests outstanding+buffered. No response lost. Resume yields consecutive PCs.
3. Redirect to 0x103 with 2 responses in flight -> both dropped. Next instr_pc=0x100. No request issued until discard=0.
4. Redirect coinciding with rsp_valid and instr_ready -> that response dropped, no pop reported, discard=outstanding-1. Next instr_pc equals the target.
5. Redirect to 0xFFFF_FFF8 -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. res asserted mid-FLUSH -> all outputs at reset values in the same cycle. Fetch restarts at RESET_PC. With FETCH_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared widths, fetch FSM states and the {pc, instr} entry type
package riscv_fetch_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with registered storage; clear beats push/pop
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         res,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign count   = wp - rp;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp[AW-1:0]];

    // Read/write pointers; extra MSB tells full from empty
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wp <= '0;
            rp <= '0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end

    // Entry storage needs no reset; only slots behind the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC fetch with credit-limited requests, response FIFO and redirect flush; FETCH_PERF_EN adds perf counters
module fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            res,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc, rsp_pc, target;
    logic [CW-1:0]   outstanding, discard, count, out_after_rsp;
    logic [CW:0]     in_use;
    logic            accept, push, pop, full, empty;
    fetch_entry_t    head;

    assign target         = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
    assign in_use         = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = state == RUN && !redirect_valid && in_use < (CW+1)'(FIFO_DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = state == RUN && imem_rsp_valid && !redirect_valid && (!full || pop);
    assign pop            = instr_valid && instr_ready && !redirect_valid;
    assign out_after_rsp  = outstanding - CW'(imem_rsp_valid);
    assign instr_valid    = !empty;
    assign instr_pc       = head.pc;
    assign instr_data     = head.instr;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .din   ('{pc: rsp_pc, instr: imem_rsp_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Control state, PC counters and in-flight bookkeeping; a redirect overrides everything else
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            state       <= out_after_rsp != '0 ? FLUSH : RUN;
            fetch_pc    <= target;
            rsp_pc      <= target;
            outstanding <= out_after_rsp;
            discard     <= out_after_rsp;
        end else begin
            outstanding <= out_after_rsp + CW'(accept);
            if (accept) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            if (push) rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
            if (state == BOOT) state <= RUN;
            if (state == FLUSH && imem_rsp_valid) begin
                discard <= discard - 1'b1;
                if (discard == CW'(1)) state <= RUN;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Delivered-instruction and request-stall counters, free-running and wrapping
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (instr_valid && instr_ready) perf_fetched <= perf_fetched + 1'b1;
            if (imem_req_valid && !imem_req_ready) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked every cycle against a queue-based model of the fetch stream
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 0, res = 0;
    logic        imem_req_valid, imem_req_ready = 0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        instr_valid, instr_ready = 0;
    logic [31:0] instr_data, instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .res            (res),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; bit stale; int due;} req_t;
    typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;

    req_t        pend[$];
    ent_t        q[$];
    logic [31:0] dl_pc[$];
    int          checks = 0, errors = 0, cyc = 0, stale_cnt = 0;
    bit          boot = 1;
    logic [31:0] mpc = RPC, m_fetched = 0, m_stall = 0;
    int          rdy_pct = 100, rsp_pct = 100, ready_pct = 100, redir_pm = 0, dmin = 1, dmax = 1;
    bit          force_redir = 0, hold_rsp = 0, redir_on_rsp = 0, hit = 0;
    logic [31:0] force_pc = 0;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, compare outputs with the model, then advance the model
    task automatic step();
        bit   rsp, exp_req, acc, pop;
        req_t r;
        @(negedge clk);
        imem_req_ready = $urandom_range(99) < rdy_pct;
        rsp = pend.size() > 0 && !hold_rsp && pend[0].due <= cyc && $urandom_range(99) < rsp_pct;
        imem_rsp_valid = rsp;
        imem_rsp_data = rsp ? hash(pend[0].addr) : $urandom;
        redirect_valid = force_redir || (redir_on_rsp && rsp && q.size() > 0) || $urandom_range(999) < redir_pm;
        redirect_pc = force_redir ? force_pc : (redir_on_rsp ? 32'h0000_2000 : $urandom);
        if (redir_on_rsp && redirect_valid) hit = 1;
        instr_ready = redir_on_rsp ? 1'b1 : $urandom_range(99) < ready_pct;
        force_redir = 0;
        #1;
        exp_req = !boot && stale_cnt == 0 && !redirect_valid && pend.size() + q.size() < DEPTH;
        chk("req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("req_addr", imem_req_addr, mpc);
        chk("instr_valid", instr_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr_data", instr_data, q[0].data);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stall);
`endif
        acc = exp_req && imem_req_ready;
        pop = q.size() > 0 && instr_ready;
        if (exp_req && !imem_req_ready) m_stall++;
        if (pop) m_fetched++;
        boot = 0;
        if (rsp) begin
            r = pend.pop_front();
            if (r.stale) stale_cnt--;
        end
        if (redirect_valid) begin
            q.delete();
            foreach (pend[i]) pend[i].stale = 1;
            stale_cnt = pend.size();
            mpc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (pop) begin
                dl_pc.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (rsp && !r.stale) q.push_back('{r.addr, hash(r.addr)});
            if (acc) begin
                pend.push_back('{mpc, 1'b0, cyc + int'($urandom_range(dmax, dmin))});
                mpc += 4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 0;
        imem_rsp_valid = 0;
        redirect_valid = 0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_stall", perf_stall, 0);
`endif
        pend.delete();
        q.delete();
        stale_cnt = 0;
        mpc = RPC;
        boot = 1;
        m_fetched = 0;
        m_stall = 0;
        @(posedge clk);
        #2 res = 1;
    endtask

    task automatic wait_dl(input int n, input string nm);
        int k = 0;
        while (dl_pc.size() < n && k < 200) begin
            step();
            k++;
        end
        chk(nm, dl_pc.size() >= n, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, k;
        do_reset();
        // Straight-line fetch with a one-cycle memory
        wait_dl(3, "boot_stream");
        if (dl_pc.size() >= 3) begin
            chk("first_pc0", dl_pc[0], 32'h0);
            chk("first_pc1", dl_pc[1], 32'h4);
            chk("first_pc2", dl_pc[2], 32'h8);
        end
        // Decode stalls: buffer fills to capacity and nothing is lost
        ready_pct = 0;
        repeat (10) step();
        chk("stall_full_valid", instr_valid, 1);
        ready_pct = 100;
        repeat (10) step();
        // Redirect to an unaligned target with two responses in flight
        dmin = 4; dmax = 4;
        k = 0;
        while (pend.size() < 2 && k < 50) begin step(); k++; end
        chk("two_in_flight", pend.size(), 2);
        hold_rsp = 1; force_redir = 1; force_pc = 32'h0000_0103;
        step();
        hold_rsp = 0;
        m = dl_pc.size();
        wait_dl(m + 1, "redir_103_stream");
        if (dl_pc.size() > m) chk("redir_103_pc", dl_pc[m], 32'h0000_0100);
        // Redirect in the same cycle as a response and a decode handshake
        dmin = 1; dmax = 1; ready_pct = 50; hit = 0; redir_on_rsp = 1;
        k = 0;
        while (!hit && k < 100) begin step(); k++; end
        redir_on_rsp = 0; ready_pct = 100;
        chk("redir_on_rsp_hit", hit, 1);
        m = dl_pc.size();
        wait_dl(m + 1, "redir_rsp_stream");
        if (dl_pc.size() > m) chk("redir_rsp_pc", dl_pc[m], 32'h0000_2000);
        // Address wrap at the top of memory
        dmin = 1; dmax = 3; force_redir = 1; force_pc = 32'hFFFF_FFF8;
        step();
        m = dl_pc.size();
        wait_dl(m + 3, "wrap_stream");
        if (dl_pc.size() >= m + 3) begin
            chk("wrap_pc0", dl_pc[m], 32'hFFFF_FFF8);
            chk("wrap_pc1", dl_pc[m+1], 32'hFFFF_FFFC);
            chk("wrap_pc2", dl_pc[m+2], 32'h0000_0000);
        end
        // Reset while flushing
        dmin = 5; dmax = 5;
        k = 0;
        while (pend.size() < 1 && k < 50) begin step(); k++; end
        hold_rsp = 1; force_redir = 1; force_pc = 32'h0000_0040;
        step();
        hold_rsp = 0;
        chk("flush_no_req", imem_req_valid, 0);
        do_reset();
        dmin = 1; dmax = 2;
        m = dl_pc.size();
        wait_dl(m + 1, "post_reset_stream");
        if (dl_pc.size() > m) chk("post_reset_pc", dl_pc[m], RPC);
        // Randomized traffic
        repeat (15) begin
            rdy_pct = $urandom_range(100, 20);
            rsp_pct = $urandom_range(100, 30);
            ready_pct = $urandom_range(100, 10);
            redir_pm = $urandom_range(40);
            dmin = $urandom_range(3, 1);
            dmax = dmin + $urandom_range(3);
            repeat (200) step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
